// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 64;

    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory inputs and per-stage enable/flush outputs of pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the three performance counters to the bundle.
interface pipe_ctrl_if;

    logic ld_use_stall;
    logic redirect;
    logic dmem_req;
    logic dmem_ready;

    logic pc_we;
    logic pc_redirect;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_flush;
    logic mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
    logic [31:0] perf_mem_wait;
`endif

    modport master (
        output ld_use_stall, redirect, dmem_req, dmem_ready,
        input  pc_we, pc_redirect, if_id_we, if_id_flush,
        input  id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cycles, perf_flushes, perf_mem_wait
`endif
    );

    modport slave (
        input  ld_use_stall, redirect, dmem_req, dmem_ready,
        output pc_we, pc_redirect, if_id_we, if_id_flush,
        output id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cycles, perf_flushes, perf_mem_wait
`endif
    );

endinterface

// File: rtl/pipe_ctrl_watchdog.sv
// Memory-wait watchdog: saturating wait counter, expiry compare and a
// sticky timeout flag that only reset clears.
module pipe_ctrl_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired,
    output logic timeout_flag
);

    localparam int              CW   = cnt_width(MEM_TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0]   SAT  = {CW{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (tick && (cnt_q != SAT))
            cnt_d = cnt_q + 1'b1;
    end

    // Compare the post-increment value so the freeze spans MEM_TIMEOUT-1
    // wait cycles on top of the cycle that entered the wait.
    assign expired = tick && (cnt_d == LAST);
    assign flag_d  = flag_q | expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_flag = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stalls, flushes and memory-wait freeze
// for the 5-stage core. Optional PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  pc
);

    state_e state_q, state_d;
    logic   wd_clear, wd_tick, wd_expired, wd_flag;
    logic   freeze;

    assign wd_clear = (state_q == RUN) && pc.dmem_req && !pc.dmem_ready;
    assign wd_tick  = (state_q == MEM_WAIT) && !pc.dmem_ready;
    assign freeze   = wd_clear || wd_tick;

    pipe_ctrl_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .clear        (wd_clear),
        .tick         (wd_tick),
        .expired      (wd_expired),
        .timeout_flag (wd_flag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (pc.dmem_req && !pc.dmem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (pc.dmem_ready || wd_expired)   state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // The release cycle out of MEM_WAIT falls through to the RUN priority
    // rules, so a redirect or stall held during the freeze lands there.
    always_comb begin
        pc.pc_we        = 1'b1;
        pc.pc_redirect  = 1'b0;
        pc.if_id_we     = 1'b1;
        pc.if_id_flush  = 1'b0;
        pc.id_ex_we     = 1'b1;
        pc.id_ex_flush  = 1'b0;
        pc.ex_mem_we    = 1'b1;
        pc.mem_wb_flush = 1'b0;
        if (reset) begin
            pc.pc_we        = 1'b0;
            pc.if_id_we     = 1'b0;
            pc.if_id_flush  = 1'b1;
            pc.id_ex_we     = 1'b0;
            pc.id_ex_flush  = 1'b1;
            pc.ex_mem_we    = 1'b0;
            pc.mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc.pc_we        = 1'b0;
            pc.if_id_we     = 1'b0;
            pc.id_ex_we     = 1'b0;
            pc.ex_mem_we    = 1'b0;
            pc.mem_wb_flush = 1'b1;
        end else if (pc.redirect) begin
            pc.pc_redirect  = 1'b1;
            pc.if_id_flush  = 1'b1;
            pc.id_ex_flush  = 1'b1;
        end else if (pc.ld_use_stall) begin
            pc.pc_we        = 1'b0;
            pc.if_id_we     = 1'b0;
            pc.id_ex_flush  = 1'b1;
        end
    end

    assign pc.mem_timeout = wd_flag;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] wait_cnt_q,  wait_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (freeze)
            wait_cnt_d = wait_cnt_q + 32'd1;
        else if (pc.redirect)
            flush_cnt_d = flush_cnt_q + 32'd1;
        else if (pc.ld_use_stall)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign pc.perf_stall_cycles = stall_cnt_q;
    assign pc.perf_flushes      = flush_cnt_q;
    assign pc.perf_mem_wait     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle comparison against a freeze-length
// model plus hand-computed literal expectations at key points.
module tb_pipe_ctrl;

    localparam int MT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Model: are we inside an access that already froze, how many freeze
    // cycles that access has used, and whether the watchdog ever fired.
    bit   m_wait = 1'b0;
    int   m_frz  = 0;
    bit   m_to   = 1'b0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (bus)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: got no finish, exp finish before 200000");
        $fatal(1);
    end

    function automatic bit model_frozen();
        if (m_wait) return !bus.dmem_ready;
        return bus.dmem_req && !bus.dmem_ready;
    endfunction

    // {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    //  ex_mem_we, mem_wb_flush, mem_timeout}
    function automatic logic [8:0] exp_vec();
        if (reset)               return 9'b000101010;
        if (model_frozen())      return {8'b00000001, m_to};
        if (bus.redirect)        return {8'b11111110, m_to};
        if (bus.ld_use_stall)    return {8'b00001110, m_to};
        return {8'b10101010, m_to};
    endfunction

    logic [8:0] dut_vec;
    assign dut_vec = {bus.pc_we, bus.pc_redirect, bus.if_id_we, bus.if_id_flush,
                      bus.id_ex_we, bus.id_ex_flush, bus.ex_mem_we,
                      bus.mem_wb_flush, bus.mem_timeout};

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (reset) begin
            m_wait <= 1'b0;
            m_frz  <= 0;
            m_to   <= 1'b0;
        end else if (model_frozen()) begin
            if (m_frz + 1 >= MT) begin
                m_to   <= 1'b1;
                m_wait <= 1'b0;
                m_frz  <= 0;
            end else begin
                m_wait <= 1'b1;
                m_frz  <= m_frz + 1;
            end
        end else begin
            m_wait <= 1'b0;
            m_frz  <= 0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL cycle %0d model_cmp: got %b exp %b", cyc_n, dut_vec, exp_vec());
        end
    end

    task automatic lit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle %0d %s: got %b exp %b", cyc_n, name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic ld, input logic rd,
                       input logic rq, input logic rdy);
        @(posedge clk);
        #1;
        reset            = r;
        bus.ld_use_stall = ld;
        bus.redirect     = rd;
        bus.dmem_req     = rq;
        bus.dmem_ready   = rdy;
        @(negedge clk);
    endtask

    initial begin
        bus.ld_use_stall = 1'b0;
        bus.redirect     = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_ready   = 1'b0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        lit("rst_pc_we",      bus.pc_we,        1'b0);
        lit("rst_mwb_flush",  bus.mem_wb_flush, 1'b1);
        lit("rst_timeout",    bus.mem_timeout,  1'b0);

        cyc(0, 0, 0, 0, 0);
        lit("run_pc_we",      bus.pc_we,        1'b1);

        // load-use for exactly one cycle
        cyc(0, 1, 0, 0, 0);
        lit("stall_pc_we",    bus.pc_we,        1'b0);
        lit("stall_if_id_we", bus.if_id_we,     1'b0);
        lit("stall_id_ex_fl", bus.id_ex_flush,  1'b1);
        cyc(0, 0, 0, 0, 0);
        lit("post_stall_we",  bus.if_id_we,     1'b1);

        // redirect overrides load-use
        cyc(0, 1, 1, 0, 0);
        lit("rd_pc_redirect", bus.pc_redirect,  1'b1);
        lit("rd_pc_we",       bus.pc_we,        1'b1);
        lit("rd_if_id_flush", bus.if_id_flush,  1'b1);

        // single-cycle access: no freeze
        cyc(0, 0, 0, 1, 1);
        lit("single_ex_we",   bus.ex_mem_we,    1'b1);

        // 3-cycle access
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0);
            lit("m3_ex_mem_we",  bus.ex_mem_we,    1'b0);
            lit("m3_mwb_flush",  bus.mem_wb_flush, 1'b1);
        end
        cyc(0, 0, 0, 1, 1);
        lit("m3_release_we",  bus.ex_mem_we,    1'b1);
        lit("m3_timeout",     bus.mem_timeout,  1'b0);

        // back-to-back access re-evaluated in RUN after release
        cyc(0, 0, 0, 1, 0);
        lit("b2b_mwb_flush",  bus.mem_wb_flush, 1'b1);
        cyc(0, 0, 0, 1, 1);

        // redirect held through freeze
        cyc(0, 0, 1, 1, 0);
        lit("rdf_redirect0",  bus.pc_redirect,  1'b0);
        cyc(0, 0, 1, 1, 0);
        lit("rdf_redirect1",  bus.pc_redirect,  1'b0);
        cyc(0, 0, 1, 1, 1);
        lit("rdf_release",    bus.pc_redirect,  1'b1);

        // load-use held through freeze
        cyc(0, 1, 0, 1, 0);
        lit("ldf_pc_we",      bus.pc_we,        1'b0);
        cyc(0, 1, 0, 1, 1);
        lit("ldf_id_ex_fl",   bus.id_ex_flush,  1'b1);
        lit("ldf_ex_mem_we",  bus.ex_mem_we,    1'b1);

        // reset in the middle of a wait
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        lit("rstw_pc_we",     bus.pc_we,        1'b0);
        lit("rstw_if_id_fl",  bus.if_id_flush,  1'b1);
        cyc(0, 0, 0, 0, 0);
        lit("rstw_run",       bus.pc_we,        1'b1);

        // watchdog: memory never answers
        for (int i = 0; i < MT; i++) begin
            cyc(0, 0, 0, 1, 0);
            lit("wd_freeze",     bus.mem_wb_flush, 1'b1);
            lit("wd_to_low",     bus.mem_timeout,  1'b0);
        end
        cyc(0, 0, 0, 0, 0);
        lit("wd_release",     bus.pc_we,        1'b1);
        lit("wd_timeout",     bus.mem_timeout,  1'b1);

        // request still pending after a timeout freezes again; flag stays set
        for (int i = 0; i < MT + 2; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        lit("wd_sticky",      bus.mem_timeout,  1'b1);

        cyc(1, 0, 0, 0, 0);
        lit("wd_rst_clear",   bus.mem_timeout,  1'b0);
        cyc(0, 0, 0, 0, 0);
        lit("wd_after_rst",   bus.mem_timeout,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It turns the hazard detector's load-use stall and control-transfer flush into per-stage register enables and flushes. It also freezes the whole pipeline while a data-memory access waits on a multi-cycle memory, and runs a watchdog on that wait. It sits between the hazard detection unit, the data-memory interface and the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- MEM_TIMEOUT, default 64: maximum number of MEM_WAIT cycles before the watchdog forces release. Legal range 2..1023.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset (one clock; reset asynchronous and active-high)
- ld_use_stall  in  1  load-use hazard from the hazard unit (ID stage)
- redirect  in  1  taken branch, jal or jalr resolved in EX
- dmem_req  in  1  MEM stage is issuing a data-memory load or store
- dmem_ready  in  1  data memory completes the current access this cycle
- pc_we  out  1  PC register write enable
- pc_redirect  out  1  PC mux selects the EX target
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_we  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0)
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_flush  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky flag: the watchdog fired

## Operation
- FSM states: RUN, MEM_WAIT.
- Outputs are Mealy: combinational from the current state and inputs.
- **RUN, dmem_req=1 and dmem_ready=0 (freeze):**
  - pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_flush=1.
  - redirect and ld_use_stall are ignored.
  - Next state is MEM_WAIT; watchdog counter cleared to 0.
- **RUN, otherwise**, outputs by priority:
  - redirect=1: pc_redirect=1, pc_we=1, if_id_flush=1, id_ex_flush=1. The load-use stall is overridden, because the stalled instruction is on the wrong path.
  - ld_use_stall=1: pc_we=0, if_id_we=0, id_ex_flush=1.
  - Neither: all enables 1, all flushes 0.
- **MEM_WAIT, dmem_ready=0:**
  - Freeze outputs as above.
  - Counter increments.
  - When the counter equals MEM_TIMEOUT-1, next state is RUN and mem_timeout is set.
- **MEM_WAIT, dmem_ready=1:**
  - Release cycle. Outputs follow the RUN priority rules, so a pending redirect or load-use stall held in the frozen stages now takes effect.
  - Next state is RUN.
- The counter is $clog2(MEM_TIMEOUT) bits wide, saturates and never wraps, and is cleared on entry to MEM_WAIT.
- mem_timeout is sticky; only reset clears it.
- A new dmem_req in the release cycle does not re-freeze. It is re-evaluated next cycle in RUN.

## Timing
- **Reset values:** state=RUN, counter=0, mem_timeout=0.
- **Outputs while reset is asserted:** all *_we=0, pc_redirect=0, if_id_flush=id_ex_flush=mem_wb_flush=1.
- **Single-cycle access** (dmem_ready=1 in the same cycle as dmem_req): zero freeze cycles.
- **N-cycle access:** freeze for N-1 cycles, then release on the cycle dmem_ready is high.
- **Watchdog:** freeze lasts at most MEM_TIMEOUT cycles (1 in RUN plus MEM_TIMEOUT-1 in MEM_WAIT). Release happens on the next cycle, with mem_timeout high from that cycle.
- **Redirect penalty:** 2 cycles (IF/ID and ID/EX flushed), with no extra FSM state.
- **Reset mid-MEM_WAIT:** returns to RUN immediately (asynchronous). Any in-flight access is abandoned.

## Configuration
- PIPE_CTRL_PERF_EN
  - Defined: adds outputs perf_stall_cycles[31:0], perf_flushes[31:0] and perf_mem_wait[31:0].
    - perf_stall_cycles counts load-use stall cycles.
    - perf_flushes counts redirect cycles.
    - perf_mem_wait counts freeze cycles.
    - All three reset to 0 and wrap at 2^32.
  - Undefined: the ports and counters are absent. Control behaviour is identical either way.

## Structure
- pipe_ctrl_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT)
  - the default MEM_TIMEOUT constant
  - a localparam function for the counter width
- Sub-module pipe_ctrl_watchdog holds the counter, the compare and the sticky mem_timeout flop.
  - Ports: clk, reset, clear, tick, expired, timeout_flag.

## Test plan
- **Reset:** assert reset mid-stream -> all enables 0, flushes 1, mem_timeout=0. Deassert -> state RUN, pc_we=1.
- **Load-use:** ld_use_stall=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_flush=1 for exactly that cycle. Next cycle all enables 1.
- **Redirect vs stall:** redirect=1 and ld_use_stall=1 together -> pc_redirect=1, pc_we=1, if_id_flush=id_ex_flush=1.
- **3-cycle memory:** dmem_req=1 with dmem_ready low for 2 cycles, then high -> ex_mem_we=0 and mem_wb_flush=1 for 2 cycles, release on the 3rd, mem_timeout stays 0.
- **Redirect during freeze:** redirect held high through the freeze -> pc_redirect=0 while frozen, pc_redirect=1 on the release cycle.
- **Watchdog:** MEM_TIMEOUT=4, dmem_ready never asserted -> 4 freeze cycles, then RUN with mem_timeout=1, which stays 1 until reset.
